// File: rtl/k16_mem_arbiter.sv
// k16_mem_arbiter: shares one single-port synchronous RAM between the K16 CPU
// and the video fetch unit. Video wins a contended clock unless the CPU has
// already lost STARVE_LIMIT contended clocks in a row. Read data returns one
// clock after the grant and is steered by an owner register.
module k16_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_data_out,
    input  logic        cpu_write,
    output logic        cpu_hold,
    output logic [15:0] cpu_data_in,
    input  logic        vid_req,
    input  logic [15:0] vid_address,
    output logic        vid_ack,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data_out,
    output logic        mem_write,
    input  logic [15:0] mem_data_in,
    output logic [15:0] stall_count
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

    owner_t        owner;
    owner_t        owner_next;
    logic          owner_write;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_next;
    logic [15:0]   hold_reg;
    logic          cpu_grant;
    logic          vid_grant;

    // Pick at most one winner this clock; nothing is granted while in reset
    always_comb begin
        cpu_grant = 1'b0;
        vid_grant = 1'b0;
        if (reset) begin
            if (cpu_req && vid_req) begin
                if (starve_cnt == LIMIT) begin
                    cpu_grant = 1'b1;
                end else begin
                    vid_grant = 1'b1;
                end
            end else begin
                cpu_grant = cpu_req;
                vid_grant = vid_req;
            end
        end
    end

    // Route the winner onto the RAM port; idle clocks present the CPU address
    always_comb begin
        mem_address  = cpu_address;
        mem_data_out = cpu_data_out;
        mem_write    = 1'b0;
        if (vid_grant) begin
            mem_address  = vid_address;
            mem_data_out = 16'h0000;
        end else if (cpu_grant) begin
            mem_write = cpu_write;
        end
    end

    assign cpu_hold = reset & cpu_req & ~cpu_grant;
    assign vid_ack  = vid_grant;

    // Next owner and starvation count; the count only grows while video keeps winning
    always_comb begin
        owner_next  = OWN_NONE;
        starve_next = starve_cnt;
        if (cpu_grant) begin
            owner_next = OWN_CPU;
        end else if (vid_grant) begin
            owner_next = OWN_VID;
        end
        if (cpu_grant || !cpu_req) begin
            starve_next = '0;
        end else if (vid_grant && (starve_cnt != LIMIT)) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    // Arbitration state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner       <= OWN_NONE;
            owner_write <= 1'b0;
            starve_cnt  <= '0;
        end else begin
            owner       <= owner_next;
            owner_write <= cpu_grant & cpu_write;
            starve_cnt  <= starve_next;
        end
    end

    // Keep the last CPU read result so a stalled CPU sees stable data
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_reg <= 16'h0000;
        end else if ((owner == OWN_CPU) && !owner_write) begin
            hold_reg <= mem_data_in;
        end
    end

    // Count stalled CPU clocks, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= 16'h0000;
        end else if (cpu_hold && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    // Steer the returning RAM word to whoever owned the previous clock; a
    // video return landing in a reset clock is dropped
    always_comb begin
        cpu_data_in = hold_reg;
        vid_valid   = 1'b0;
        vid_data    = 16'h0000;
        if (owner == OWN_CPU) begin
            cpu_data_in = mem_data_in;
        end
        if (reset && (owner == OWN_VID)) begin
            vid_valid = 1'b1;
            vid_data  = mem_data_in;
        end
    end

endmodule

// File: tb/tb_k16_mem_arbiter.sv
// tb_k16_mem_arbiter: directed vector table plus hand-written contention,
// reset and saturation sequences for k16_mem_arbiter.
module tb_k16_mem_arbiter;

    typedef struct {
        logic        rst;
        logic        creq;
        logic [15:0] caddr;
        logic [15:0] cdout;
        logic        cwr;
        logic        vreq;
        logic [15:0] vaddr;
        logic        e_hold;
        logic        e_ack;
        logic        e_mwr;
        logic [15:0] e_maddr;
        logic        chk_cdin;
        logic [15:0] e_cdin;
        logic        e_vvalid;
        logic [15:0] e_vdata;
        logic [15:0] e_stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic [15:0] cpu_address;
    logic [15:0] cpu_data_out;
    logic        cpu_write;
    logic        cpu_hold;
    logic [15:0] cpu_data_in;
    logic        vid_req;
    logic [15:0] vid_address;
    logic        vid_ack;
    logic [15:0] vid_data;
    logic        vid_valid;
    logic [15:0] mem_address;
    logic [15:0] mem_data_out;
    logic        mem_write;
    logic [15:0] mem_data_in;
    logic [15:0] stall_count;

    logic        sat_reset;
    logic        sat_cpu_hold;
    logic [15:0] sat_cpu_data_in;
    logic        sat_vid_ack;
    logic [15:0] sat_vid_data;
    logic        sat_vid_valid;
    logic [15:0] sat_mem_address;
    logic [15:0] sat_mem_data_out;
    logic        sat_mem_write;
    logic [15:0] sat_stall_count;

    logic [15:0] ram [0:65535];

    int tests_run = 0;
    int tests_failed = 0;
    int exp_stall = 0;
    logic [15:0] exp_hold = 16'h0000;
    vec_t vecs [14];

    always #5 clk = ~clk;

    // Single-port synchronous RAM, read-first, one clock of read latency
    always @(posedge clk) begin
        if (mem_write) ram[mem_address] <= mem_data_out;
        mem_data_in <= ram[mem_address];
    end

    k16_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
        .cpu_write(cpu_write), .cpu_hold(cpu_hold), .cpu_data_in(cpu_data_in),
        .vid_req(vid_req), .vid_address(vid_address), .vid_ack(vid_ack),
        .vid_data(vid_data), .vid_valid(vid_valid),
        .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_write(mem_write),
        .mem_data_in(mem_data_in), .stall_count(stall_count)
    );

    // Instance whose CPU loses every contended clock, used for counter saturation
    k16_mem_arbiter #(.STARVE_LIMIT(100000)) dut_sat (
        .clk(clk), .reset(sat_reset),
        .cpu_req(1'b1), .cpu_address(16'h0000), .cpu_data_out(16'h0000),
        .cpu_write(1'b0), .cpu_hold(sat_cpu_hold), .cpu_data_in(sat_cpu_data_in),
        .vid_req(1'b1), .vid_address(16'h0000), .vid_ack(sat_vid_ack),
        .vid_data(sat_vid_data), .vid_valid(sat_vid_valid),
        .mem_address(sat_mem_address), .mem_data_out(sat_mem_data_out), .mem_write(sat_mem_write),
        .mem_data_in(16'h0000), .stall_count(sat_stall_count)
    );

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset        = v.rst;
        cpu_req      = v.creq;
        cpu_address  = v.caddr;
        cpu_data_out = v.cdout;
        cpu_write    = v.cwr;
        vid_req      = v.vreq;
        vid_address  = v.vaddr;
        #2;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic runContention(input string pat, input string tag);
        for (int i = 0; i < pat.len(); i++) begin
            logic is_vid;
            is_vid       = (pat[i] == "V");
            reset        = 1'b1;
            cpu_req      = 1'b1;
            cpu_address  = 16'h0001;
            cpu_data_out = 16'h0000;
            cpu_write    = 1'b0;
            vid_req      = 1'b1;
            vid_address  = 16'h8000;
            #2;
            checkOutput($sformatf("%s[%0d] vid_ack", tag, i), 16'(vid_ack), 16'(is_vid));
            checkOutput($sformatf("%s[%0d] cpu_hold", tag, i), 16'(cpu_hold), 16'(is_vid));
            checkOutput($sformatf("%s[%0d] mem_address", tag, i), mem_address,
                        is_vid ? 16'h8000 : 16'h0001);
            if (is_vid) exp_stall++;
            else exp_hold = 16'h7300;
            stepClock();
            checkOutput($sformatf("%s[%0d] vid_valid", tag, i), 16'(vid_valid), 16'(is_vid));
            checkOutput($sformatf("%s[%0d] vid_data", tag, i), vid_data,
                        is_vid ? 16'h3C41 : 16'h0000);
            checkOutput($sformatf("%s[%0d] cpu_data_in", tag, i), cpu_data_in,
                        is_vid ? exp_hold : 16'h7300);
            checkOutput($sformatf("%s[%0d] stall_count", tag, i), stall_count, 16'(exp_stall));
        end
    endtask

    initial begin
        sat_reset = 1'b0;
        //          rst  creq caddr     cdout     cwr  vreq vaddr     hold ack  mwr  maddr     chk  cdin      vv   vdata     stall
        vecs[0]  = '{1'b0,1'b1,16'h0001,16'h0005,1'b1,1'b1,16'h8000, 1'b0,1'b0,1'b0,16'h0001, 1'b1,16'h0000,1'b0,16'h0000,16'h0000};
        vecs[1]  = '{1'b1,1'b1,16'h0001,16'h7300,1'b1,1'b0,16'h0000, 1'b0,1'b0,1'b1,16'h0001, 1'b0,16'h0000,1'b0,16'h0000,16'h0000};
        vecs[2]  = '{1'b1,1'b1,16'h8000,16'h3C41,1'b1,1'b0,16'h0000, 1'b0,1'b0,1'b1,16'h8000, 1'b0,16'h0000,1'b0,16'h0000,16'h0000};
        vecs[3]  = '{1'b1,1'b1,16'h0001,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0001, 1'b1,16'h7300,1'b0,16'h0000,16'h0000};
        vecs[4]  = '{1'b1,1'b0,16'h0005,16'h0000,1'b0,1'b0,16'h1234, 1'b0,1'b0,1'b0,16'h0005, 1'b1,16'h7300,1'b0,16'h0000,16'h0000};
        vecs[5]  = '{1'b1,1'b0,16'h0007,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0007, 1'b1,16'h7300,1'b0,16'h0000,16'h0000};
        vecs[6]  = '{1'b1,1'b1,16'h0064,16'h1234,1'b1,1'b0,16'h0000, 1'b0,1'b0,1'b1,16'h0064, 1'b0,16'h0000,1'b0,16'h0000,16'h0000};
        vecs[7]  = '{1'b1,1'b0,16'h0064,16'h1234,1'b1,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0064, 1'b1,16'h7300,1'b0,16'h0000,16'h0000};
        vecs[8]  = '{1'b1,1'b1,16'h0064,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0064, 1'b1,16'h1234,1'b0,16'h0000,16'h0000};
        vecs[9]  = '{1'b1,1'b0,16'h0002,16'hFFFF,1'b1,1'b1,16'h8000, 1'b0,1'b1,1'b0,16'h8000, 1'b1,16'h1234,1'b1,16'h3C41,16'h0000};
        vecs[10] = '{1'b1,1'b1,16'h0001,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0001, 1'b1,16'h7300,1'b0,16'h0000,16'h0000};
        vecs[11] = '{1'b1,1'b0,16'h0001,16'h0000,1'b0,1'b1,16'h8000, 1'b0,1'b1,1'b0,16'h8000, 1'b1,16'h7300,1'b1,16'h3C41,16'h0000};
        vecs[12] = '{1'b1,1'b0,16'h0003,16'h0000,1'b0,1'b0,16'h0000, 1'b0,1'b0,1'b0,16'h0003, 1'b1,16'h7300,1'b0,16'h0000,16'h0000};
        vecs[13] = '{1'b1,1'b0,16'h0004,16'h0000,1'b0,1'b0,16'h8000, 1'b0,1'b0,1'b0,16'h0004, 1'b1,16'h7300,1'b0,16'h0000,16'h0000};

        for (int r = 0; r < 14; r++) begin
            applyStimulus(vecs[r]);
            checkOutput($sformatf("row%0d cpu_hold", r), 16'(cpu_hold), 16'(vecs[r].e_hold));
            checkOutput($sformatf("row%0d vid_ack", r), 16'(vid_ack), 16'(vecs[r].e_ack));
            checkOutput($sformatf("row%0d mem_write", r), 16'(mem_write), 16'(vecs[r].e_mwr));
            checkOutput($sformatf("row%0d mem_address", r), mem_address, vecs[r].e_maddr);
            stepClock();
            if (vecs[r].chk_cdin)
                checkOutput($sformatf("row%0d cpu_data_in", r), cpu_data_in, vecs[r].e_cdin);
            checkOutput($sformatf("row%0d vid_valid", r), 16'(vid_valid), 16'(vecs[r].e_vvalid));
            checkOutput($sformatf("row%0d vid_data", r), vid_data, vecs[r].e_vdata);
            checkOutput($sformatf("row%0d stall_count", r), stall_count, vecs[r].e_stall);
        end

        exp_stall = 0;
        exp_hold  = 16'h7300;
        runContention("VVVVCVVVVC", "starve");
        checkOutput("starve total stall_count", stall_count, 16'd8);

        runContention("VVV", "prereset");
        reset = 1'b0;
        #2;
        checkOutput("rst vid_ack", 16'(vid_ack), 16'd0);
        checkOutput("rst cpu_hold", 16'(cpu_hold), 16'd0);
        checkOutput("rst mem_write", 16'(mem_write), 16'd0);
        checkOutput("rst vid_valid", 16'(vid_valid), 16'd0);
        stepClock();
        checkOutput("postrst vid_valid", 16'(vid_valid), 16'd0);
        checkOutput("postrst stall_count", stall_count, 16'd0);
        checkOutput("postrst cpu_data_in", cpu_data_in, 16'd0);
        exp_stall = 0;
        exp_hold  = 16'h0000;
        runContention("VVVVC", "postrst");

        checkOutput("sat reset stall_count", sat_stall_count, 16'd0);
        sat_reset = 1'b1;
        #2;
        checkOutput("sat cpu_hold", 16'(sat_cpu_hold), 16'd1);
        for (int n = 1; n <= 70000; n++) begin
            stepClock();
            if (n == 65534) checkOutput("sat count 65534", sat_stall_count, 16'hFFFE);
            if (n == 65535) checkOutput("sat count 65535", sat_stall_count, 16'hFFFF);
            if (n == 70000) checkOutput("sat count 70000", sat_stall_count, 16'hFFFF);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
